// File: rtl/ssd_value_encoder_pkg.sv
// Shared types and constants for the seven-segment value encoder: FSM states,
// segment patterns (active-low, bit 6 = a ... bit 0 = g) and the nibble adjust step.
package ssd_enc_pkg;

    localparam int WIDTH = 14;
    localparam logic [WIDTH-1:0] BCD_MAX = 14'd9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Add-3 on every nibble that would reach 10 or more after the next doubling.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int n = 0; n < 4; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5)
                res[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
        end
        return res;
    endfunction

endpackage

// File: rtl/ssd_value_encoder_if.sv
// Control-side bundle of the encoder: value/load in, busy/done status and the
// 28 active-low segment lines (digit 0 rightmost) out towards the ssd driver.
interface ssd_value_encoder_if;
    import ssd_enc_pkg::*;

    logic [WIDTH-1:0] value;
    logic             load;
    logic             busy;
    logic             done;
    logic a0, b0, c0, d0, e0, f0, g0;
    logic a1, b1, c1, d1, e1, f1, g1;
    logic a2, b2, c2, d2, e2, f2, g2;
    logic a3, b3, c3, d3, e3, f3, g3;

    modport master (
        output value, load,
        input  busy, done,
        input  a0, b0, c0, d0, e0, f0, g0,
        input  a1, b1, c1, d1, e1, f1, g1,
        input  a2, b2, c2, d2, e2, f2, g2,
        input  a3, b3, c3, d3, e3, f3, g3
    );

    modport slave (
        input  value, load,
        output busy, done,
        output a0, b0, c0, d0, e0, f0, g0,
        output a1, b1, c1, d1, e1, f1, g1,
        output a2, b2, c2, d2, e2, f2, g2,
        output a3, b3, c3, d3, e3, f3, g3
    );

endinterface

// File: rtl/ssd_digit_rom.sv
// Combinational BCD digit to active-low abcdefg pattern; non-decimal codes go dark.
module ssd_digit_rom
    import ssd_enc_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_value_encoder.sv
// Binary to four-digit seven-segment encoder: double dabble one bit per clock, 15-clock latency,
// segments registered only at the end. SSD_ENC_BLANK_EN enables leading-zero blanking.
module ssd_value_encoder
    import ssd_enc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    ssd_value_encoder_if.slave bus
);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic [27:0]      seg_q, seg_d;
    logic             done_q, done_d;

    logic [15:0] bcd_adj;
    logic [6:0]  rom_seg [4];
    logic [6:0]  disp    [4];
    logic [3:0]  blank;

    assign bcd_adj = bcd_adjust(bcd_q);

    for (genvar g = 0; g < 4; g++) begin : g_rom
        ssd_digit_rom u_rom (
            .bcd_i (bcd_q[g*4 +: 4]),
            .seg_o (rom_seg[g])
        );
    end

`ifdef SSD_ENC_BLANK_EN
    // A digit goes dark only if it and every digit to its left are zero.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = (bcd_q[15:12] == 4'd0);
        blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
        blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
    end
`else
    assign blank = 4'b0000;
`endif

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            disp[g] = rom_seg[g];
            if (ovf_q)
                disp[g] = SEG_DASH;
            else if (blank[g])
                disp[g] = SEG_BLANK;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    state_d = SHIFT;
                    cnt_d   = 4'(WIDTH - 1);
                    bin_d   = bus.value;
                    bcd_d   = '0;
                    ovf_d   = (bus.value > BCD_MAX);
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
                cnt_d          = cnt_q - 4'd1;
                if (cnt_q == 4'd0)
                    state_d = ENCODE;
            end
            ENCODE: begin
                seg_d   = {disp[3], disp[2], disp[1], disp[0]};
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            seg_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            seg_q   <= seg_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign {bus.a3, bus.b3, bus.c3, bus.d3, bus.e3, bus.f3, bus.g3,
            bus.a2, bus.b2, bus.c2, bus.d2, bus.e2, bus.f2, bus.g2,
            bus.a1, bus.b1, bus.c1, bus.d1, bus.e1, bus.f1, bus.g1,
            bus.a0, bus.b0, bus.c0, bus.d0, bus.e0, bus.f0, bus.g0} = seg_q;

endmodule

// File: tb/tb_ssd_value_encoder.sv
// Directed bench for ssd_value_encoder: reset, conversions, range ends, load while busy, mid-conversion reset.
module tb_ssd_value_encoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ssd_value_encoder_if bus ();

    ssd_value_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [27:0] segs;
    assign segs = {bus.a3, bus.b3, bus.c3, bus.d3, bus.e3, bus.f3, bus.g3,
                   bus.a2, bus.b2, bus.c2, bus.d2, bus.e2, bus.f2, bus.g2,
                   bus.a1, bus.b1, bus.c1, bus.d1, bus.e1, bus.f1, bus.g1,
                   bus.a0, bus.b0, bus.c0, bus.d0, bus.e0, bus.f0, bus.g0};

    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PD = 7'b1111110;

    localparam logic [27:0] E_1234 = {P1, P2, P3, P4};
    localparam logic [27:0] E_9999 = {P9, P9, P9, P9};
    localparam logic [27:0] E_DASH = {PD, PD, PD, PD};
    localparam logic [27:0] E_5678 = {P5, P6, P7, P8};
    localparam logic [27:0] E_8888 = {P8, P8, P8, P8};
    localparam logic [27:0] E_OFF  = {PB, PB, PB, PB};
`ifdef SSD_ENC_BLANK_EN
    localparam logic [27:0] E_0    = {PB, PB, PB, P0};
    localparam logic [27:0] E_42   = {PB, PB, P4, P2};
    localparam logic [27:0] E_77   = {PB, PB, P7, P7};
`else
    localparam logic [27:0] E_0    = {P0, P0, P0, P0};
    localparam logic [27:0] E_42   = {P0, P0, P4, P2};
    localparam logic [27:0] E_77   = {P0, P0, P7, P7};
`endif

    logic [27:0] exp_disp;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full conversion: accept, 14 shift cycles with held display, done pulse, done release.
    task automatic convert(input logic [13:0] v, input logic [27:0] exp, input string tag);
        bus.value = v;
        bus.load  = 1'b1;
        step;
        bus.load  = 1'b0;
        bus.value = ~v;
        check({tag, "_accept"}, {30'd0, bus.busy, bus.done}, 32'd2);
        for (int i = 1; i <= 14; i++) begin
            step;
            check({tag, "_shift"}, {2'b00, bus.busy, bus.done, segs}, {2'b00, 2'b10, exp_disp});
        end
        step;
        check({tag, "_done"}, {2'b00, bus.busy, bus.done, segs}, {2'b00, 2'b01, exp});
        exp_disp = exp;
        step;
        check({tag, "_after"}, {2'b00, bus.busy, bus.done, segs}, {2'b00, 2'b00, exp});
    endtask

    initial begin
        // Reset held with a simultaneous load: reset must win.
        reset     = 1'b0;
        bus.load  = 1'b1;
        bus.value = 14'd1234;
        repeat (3) step;
        check("reset_state", {2'b00, bus.busy, bus.done, segs}, {2'b00, 2'b00, E_OFF});
        bus.load  = 1'b0;
        reset     = 1'b1;
        exp_disp  = E_OFF;
        step;
        check("idle_after_reset", {30'd0, bus.busy, bus.done}, 32'd0);

        convert(14'd1234,  E_1234, "v1234");
        convert(14'd9999,  E_9999, "v9999");
        convert(14'd10000, E_DASH, "v10000");
        convert(14'd16383, E_DASH, "v16383");
        convert(14'd0,     E_0,    "v0");
        convert(14'd42,    E_42,   "v42");

        // Load while busy: pulses at +3 and +15 ignored, load at +16 accepted.
        bus.value = 14'd1234;
        bus.load  = 1'b1;
        step;
        for (int c = 1; c <= 31; c++) begin
            bus.load  = (c == 3) || (c == 15) || (c == 16);
            bus.value = bus.load ? 14'd5678 : 14'd0;
            step;
            if (c == 3)
                check("busy_ign_p3", {30'd0, bus.busy, bus.done}, 32'd2);
            if (c == 15)
                check("busy_done_1234", {2'b00, bus.busy, bus.done, segs}, {2'b00, 2'b01, E_1234});
            if (c == 16)
                check("busy_reaccept", {2'b00, bus.busy, bus.done, segs}, {2'b00, 2'b10, E_1234});
            if (c == 30)
                check("busy_hold_5678", {2'b00, bus.busy, bus.done, segs}, {2'b00, 2'b10, E_1234});
            if (c == 31)
                check("busy_done_5678", {2'b00, bus.busy, bus.done, segs}, {2'b00, 2'b01, E_5678});
        end
        bus.load = 1'b0;
        exp_disp = E_5678;
        step;

        // Reset mid-conversion with 8888 on the display.
        convert(14'd8888, E_8888, "v8888");
        bus.value = 14'd1234;
        bus.load  = 1'b1;
        step;
        bus.load  = 1'b0;
        for (int c = 1; c <= 6; c++) step;
        reset     = 1'b0;
        bus.load  = 1'b1;
        bus.value = 14'd77;
        step;
        check("midreset_blank", {2'b00, bus.busy, bus.done, segs}, {2'b00, 2'b00, E_OFF});
        reset    = 1'b1;
        bus.load = 1'b0;
        exp_disp = E_OFF;
        for (int c = 8; c <= 16; c++) begin
            step;
            check("midreset_no_done", {2'b00, bus.busy, bus.done, segs}, {2'b00, 2'b00, E_OFF});
        end
        convert(14'd77, E_77, "v0077");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
